mac_seq_ctrl: RTL and testbench

- Parametrised sequencer for the register-file/multiplier/RAM datapath; generalises the fixed single-pair control flow.
- Processes COUNT operand pairs per job: reads A and B operands from the register file, launches the multiplier, waits for its result, writes the product to RAM at incrementing addresses, then signals done.
- Sits between the top-level command source and the regfile/multiplier/RAM datapath.

---
 rtl/mac_seq_pkg.sv | 28 ++
 rtl/mac_seq_timeout.sv | 29 ++
 rtl/mac_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding, defaults and helpers for the MAC sequencer
// Contents: state_t (IDLE..DONE, ST_W bits), default parameter values,
//           timeout_width() sizing helper for the WAIT timeout counter.
package mac_seq_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_MUL  = 3'd3,
        ST_WAIT = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam int DEF_RF_AW       = 3;
    localparam int DEF_RAM_AW      = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_MUL_TIMEOUT = 15;

    // The counter is loaded with cycles-1, so it needs clog2(cycles) bits (min 1).
    function automatic int timeout_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mac_seq_timeout.sv
// rtl/mac_seq_timeout.sv - loadable down-counter with expired flag for the multiplier wait
// Ports: clk, reset (async, active-high), i_load/i_load_val (reload),
//        i_dec (count down, saturates at 0), o_expired (counter is 0).
module mac_seq_timeout #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequencer driving regfile reads, multiplier launch and RAM writes for COUNT pairs
// Ports: clk, reset (async, active-high); job request start/base_a/base_b/count/ram_base;
//        mul_valid from the multiplier; regfile rf_re/rf_addr/ld_a/ld_b; mul_go;
//        RAM ram_we/ram_addr; status busy/done/err/st_out.
// Optional: define MAC_SEQ_ACCUM_EN to add acc_en/acc_clr and write only the
//           accumulated result of the final pair at ram_base.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int RF_AW       = DEF_RF_AW,
    parameter int RAM_AW      = DEF_RAM_AW,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MUL_TIMEOUT = DEF_MUL_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RF_AW-1:0]  base_a,
    input  logic [RF_AW-1:0]  base_b,
    input  logic [CNT_W-1:0]  count,
    input  logic [RAM_AW-1:0] ram_base,
    input  logic              mul_valid,
    output logic              rf_re,
    output logic [RF_AW-1:0]  rf_addr,
    output logic              ld_a,
    output logic              ld_b,
    output logic              mul_go,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
`ifdef MAC_SEQ_ACCUM_EN
    output logic              acc_en,
    output logic              acc_clr,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ST_W-1:0]   st_out
);

    localparam int              TO_W    = timeout_width(MUL_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LOAD = (MUL_TIMEOUT == 0) ? '0 : TO_W'(MUL_TIMEOUT - 1);

    state_t              r_state, w_state_nxt;
    logic [RF_AW-1:0]    r_ptr_a, r_ptr_b, w_ptr_a_nxt, w_ptr_b_nxt, w_ptr_a_inc;
    logic [RAM_AW-1:0]   r_ptr_r, w_ptr_r_nxt;
    logic [CNT_W-1:0]    r_rem, w_rem_nxt;
    logic                r_err, w_err_nxt;

    logic                w_rf_re, w_ld_a, w_ld_b, w_mul_go, w_ram_we, w_busy, w_done;
    logic [RF_AW-1:0]    w_rf_addr;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic                w_to_load, w_to_dec, w_expired, w_timeout;
`ifdef MAC_SEQ_ACCUM_EN
    logic                w_acc_en, w_acc_clr;
`endif

    mac_seq_timeout #(.W(TO_W)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_to_load),
        .i_load_val (TO_LOAD),
        .i_dec      (w_to_dec),
        .o_expired  (w_expired)
    );

    // MUL_TIMEOUT == 0 means wait for the multiplier forever.
    assign w_timeout   = (MUL_TIMEOUT != 0) && w_expired;
    assign w_ptr_a_inc = r_ptr_a + 1'b1;

    // Outputs are computed for the state being entered and registered alongside it,
    // so each output is visible during the cycle its state is active. busy stays
    // high through the done cycle, which gives an empty job a one-cycle busy pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_a_nxt = r_ptr_a;
        w_ptr_b_nxt = r_ptr_b;
        w_ptr_r_nxt = r_ptr_r;
        w_rem_nxt   = r_rem;
        w_err_nxt   = r_err;
        w_rf_re     = 1'b0;
        w_rf_addr   = '0;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_mul_go    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_to_load   = 1'b0;
        w_to_dec    = 1'b0;
`ifdef MAC_SEQ_ACCUM_EN
        w_acc_en    = 1'b0;
        w_acc_clr   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_ptr_a_nxt = base_a;
                    w_ptr_b_nxt = base_b;
                    w_ptr_r_nxt = ram_base;
                    w_rem_nxt   = count;
                    w_err_nxt   = 1'b0;
                    w_busy      = 1'b1;
                    if (count == '0) begin
                        w_state_nxt = ST_DONE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD_A;
                        w_rf_re     = 1'b1;
                        w_rf_addr   = base_a;
                        w_ld_a      = 1'b1;
`ifdef MAC_SEQ_ACCUM_EN
                        w_acc_clr   = 1'b1;
`endif
                    end
                end
            end
            ST_RD_A: begin
                w_state_nxt = ST_RD_B;
                w_rf_re     = 1'b1;
                w_rf_addr   = r_ptr_b;
                w_ld_b      = 1'b1;
                w_busy      = 1'b1;
            end
            ST_RD_B: begin
                w_state_nxt = ST_MUL;
                w_mul_go    = 1'b1;
                w_busy      = 1'b1;
            end
            ST_MUL: begin
                w_state_nxt = ST_WAIT;
                w_to_load   = 1'b1;
                w_busy      = 1'b1;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                // A result arriving on the timeout cycle still counts.
                if (mul_valid) begin
                    w_state_nxt = ST_WR;
                    w_ram_addr  = r_ptr_r;
`ifdef MAC_SEQ_ACCUM_EN
                    if (r_rem == CNT_W'(1)) begin
                        w_ram_we = 1'b1;
                    end else begin
                        w_acc_en = 1'b1;
                    end
`else
                    w_ram_we    = 1'b1;
`endif
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                    w_done      = 1'b1;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            ST_WR: begin
                w_busy      = 1'b1;
                w_ptr_a_nxt = w_ptr_a_inc;
                w_ptr_b_nxt = r_ptr_b + 1'b1;
`ifndef MAC_SEQ_ACCUM_EN
                w_ptr_r_nxt = r_ptr_r + 1'b1;
`endif
                w_rem_nxt   = r_rem - 1'b1;
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = ST_RD_A;
                    w_rf_re     = 1'b1;
                    w_rf_addr   = w_ptr_a_inc;
                    w_ld_a      = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr_a  <= '0;
            r_ptr_b  <= '0;
            r_ptr_r  <= '0;
            r_rem    <= '0;
            r_err    <= 1'b0;
            rf_re    <= 1'b0;
            rf_addr  <= '0;
            ld_a     <= 1'b0;
            ld_b     <= 1'b0;
            mul_go   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MAC_SEQ_ACCUM_EN
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_ptr_a  <= w_ptr_a_nxt;
            r_ptr_b  <= w_ptr_b_nxt;
            r_ptr_r  <= w_ptr_r_nxt;
            r_rem    <= w_rem_nxt;
            r_err    <= w_err_nxt;
            rf_re    <= w_rf_re;
            rf_addr  <= w_rf_addr;
            ld_a     <= w_ld_a;
            ld_b     <= w_ld_b;
            mul_go   <= w_mul_go;
            ram_we   <= w_ram_we;
            ram_addr <= w_ram_addr;
            busy     <= w_busy;
            done     <= w_done;
`ifdef MAC_SEQ_ACCUM_EN
            acc_en   <= w_acc_en;
            acc_clr  <= w_acc_clr;
`endif
        end
    end

    assign err    = r_err;
    assign st_out = r_state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl (default or MAC_SEQ_ACCUM_EN build)
module tb_mac_seq_ctrl;

    localparam int RF_AW       = 3;
    localparam int RAM_AW      = 4;
    localparam int CNT_W       = 4;
    localparam int MUL_TIMEOUT = 15;
    localparam int RF_M        = (1 << RF_AW) - 1;
    localparam int RAM_M       = (1 << RAM_AW) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [RF_AW-1:0]  base_a = '0;
    logic [RF_AW-1:0]  base_b = '0;
    logic [CNT_W-1:0]  count = '0;
    logic [RAM_AW-1:0] ram_base = '0;
    logic              mul_valid = 1'b0;
    logic              rf_re, ld_a, ld_b, mul_go, ram_we, busy, done, err;
    logic [RF_AW-1:0]  rf_addr;
    logic [RAM_AW-1:0] ram_addr;
    logic [2:0]        st_out;
`ifdef MAC_SEQ_ACCUM_EN
    logic              acc_en, acc_clr;
`endif

    mac_seq_ctrl #(
        .RF_AW       (RF_AW),
        .RAM_AW      (RAM_AW),
        .CNT_W       (CNT_W),
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .count     (count),
        .ram_base  (ram_base),
        .mul_valid (mul_valid),
        .rf_re     (rf_re),
        .rf_addr   (rf_addr),
        .ld_a      (ld_a),
        .ld_b      (ld_b),
        .mul_go    (mul_go),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
`ifdef MAC_SEQ_ACCUM_EN
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .st_out    (st_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rf_q[$];
    int exp_ram_q[$];
    int acc_clr_n = 0;
    int acc_en_n  = 0;
    bit mul_on    = 1'b1;
    bit mul_pend  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ideal multiplier: result pulse in the cycle after mul_go.
    initial begin
        forever begin
            @(negedge clk);
            if (mul_valid) mul_valid = 1'b0;
            if (mul_pend) begin
                mul_valid = 1'b1;
                mul_pend  = 1'b0;
            end
            if (mul_go && mul_on) mul_pend = 1'b1;
        end
    end

    // Scoreboard consumer: every regfile read and RAM write must match the next expected entry.
    initial begin
        int got_rf;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rf_re) begin
                    got_rf = (ld_a ? 'h100 : 0) | (ld_b ? 'h200 : 0) | int'(rf_addr);
                    if (exp_rf_q.size() == 0) chk("rf_unexpected", got_rf, 0);
                    else chk("rf_read", got_rf, exp_rf_q.pop_front());
                end
                if (ram_we) begin
                    if (exp_ram_q.size() == 0) chk("ram_unexpected", ram_we, 0);
                    else chk("ram_addr", ram_addr, exp_ram_q.pop_front());
                end
`ifdef MAC_SEQ_ACCUM_EN
                if (acc_clr) acc_clr_n++;
                if (acc_en) acc_en_n++;
`endif
            end
        end
    end

    task automatic run_job(input int ba, input int bb, input int rb, input int cnt,
                           input bit mul_en, input bit poke, input bit exp_err, input int exp_lat);
        int lat = 0;
        int busy_n = 0;
        int wait_n = 0;
        int exp_wait;
        bit seen = 1'b0;
        exp_wait = (cnt == 0) ? 0 : (mul_en ? cnt : MUL_TIMEOUT);
        mul_on = mul_en;
        for (int i = 0; i < cnt; i++) begin
            if (mul_en || i == 0) begin
                exp_rf_q.push_back('h100 | ((ba + i) & RF_M));
                exp_rf_q.push_back('h200 | ((bb + i) & RF_M));
            end
            if (mul_en) begin
`ifdef MAC_SEQ_ACCUM_EN
                if (i == cnt - 1) exp_ram_q.push_back(rb);
`else
                exp_ram_q.push_back((rb + i) & RAM_M);
`endif
            end
        end
        @(negedge clk);
        base_a   = RF_AW'(ba);
        base_b   = RF_AW'(bb);
        ram_base = RAM_AW'(rb);
        count    = CNT_W'(cnt);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        chk("err_at_accept", err, 0);
        while (lat <= 300) begin
            if (busy) busy_n++;
            if (st_out == 3'd4) wait_n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            // A second request mid-job must be ignored.
            if (poke && lat == 3) begin
                start  = 1'b1;
                base_a = '0;
                count  = CNT_W'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("done_latency", lat, exp_lat);
        chk("busy_cycles", busy_n, exp_lat);
        chk("wait_cycles", wait_n, exp_wait);
        chk("err_at_done", err, exp_err);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        chk("rf_queue_left", exp_rf_q.size(), 0);
        chk("ram_queue_left", exp_ram_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {rf_re, ld_a, ld_b, mul_go, ram_we, busy, done, err}, 0);
        chk("reset_rf_addr", rf_addr, 0);
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_state", st_out, 0);
        reset = 1'b0;

        // Main job, with a start pulse while busy.
        run_job(1, 4, 2, 3, 1'b1, 1'b1, 1'b0, 5 * 3 + 1);
        // Empty job.
        run_job(5, 5, 9, 0, 1'b1, 1'b0, 1'b0, 1);
        // Pointer wrap.
        run_job(7, 6, 15, 2, 1'b1, 1'b0, 1'b0, 5 * 2 + 1);
        // Multiplier never answers: RD_A, RD_B, MUL, 15 WAIT cycles, DONE.
        run_job(0, 1, 3, 2, 1'b0, 1'b0, 1'b1, 3 + MUL_TIMEOUT + 1);
        // Next accepted start clears err.
        run_job(2, 3, 5, 1, 1'b1, 1'b0, 1'b0, 5 * 1 + 1);

        // Reset while waiting on the multiplier.
        mul_on = 1'b0;
        exp_rf_q.push_back('h100 | 3);
        exp_rf_q.push_back('h200 | 4);
        @(negedge clk);
        base_a = 3'd3; base_b = 3'd4; ram_base = 4'd0; count = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (st_out != 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait", st_out, 4);
        reset = 1'b1;
        #1;
        chk("midreset_ctrl", {rf_re, ld_a, ld_b, mul_go, ram_we, busy, done, err}, 0);
        chk("midreset_state", st_out, 0);
        @(negedge clk);
        chk("midreset_next_ctrl", {rf_re, ld_a, ld_b, mul_go, ram_we, busy, done, err}, 0);
        chk("midreset_next_state", st_out, 0);
        reset = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy || st_out != 3'd0) n++;
        end
        chk("post_reset_quiet", n, 0);
        chk("post_reset_rf_queue", exp_rf_q.size(), 0);

        // Recovery after reset.
        run_job(3, 3, 0, 2, 1'b1, 1'b0, 1'b0, 5 * 2 + 1);

`ifdef MAC_SEQ_ACCUM_EN
        acc_clr_n = 0;
        acc_en_n  = 0;
        run_job(1, 2, 6, 4, 1'b1, 1'b0, 1'b0, 5 * 4 + 1);
        chk("acc_clr_pulses", acc_clr_n, 1);
        chk("acc_en_pulses", acc_en_n, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
